// File: rtl/apb4_mst_pkg.sv
// Shared types and default sizing for the APB4 master bridge.
// Imported by the interface, the bridge top and the watchdog.
package apb4_mst_pkg;

    localparam int APB_ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_SLVERR  = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

endpackage

// File: rtl/apb4_mst_bridge_if.sv
// Command, response and APB4 master signal bundle for the bridge.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb4_mst_bridge_if
    import apb4_mst_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic                      req_write_i;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic [DATA_WIDTH-1:0]     req_wdata_i;
    logic [DATA_WIDTH/8-1:0]   req_strb_i;
    logic [2:0]                req_prot_i;

    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [DATA_WIDTH-1:0]     rsp_rdata_o;
    logic [1:0]                rsp_err_o;

    logic [ADDR_WIDTH-1:0]     apb_paddr_o;
    logic [2:0]                apb_pprot_o;
    logic                      apb_psel_o;
    logic                      apb_penable_o;
    logic                      apb_pwrite_o;
    logic [DATA_WIDTH-1:0]     apb_pwdata_o;
    logic [DATA_WIDTH/8-1:0]   apb_pstrb_o;
    logic                      apb_pready_i;
    logic [DATA_WIDTH-1:0]     apb_prdata_i;
    logic                      apb_pslverr_i;

    // Handshakes: a request transfers on a rising edge where req_valid_i && req_ready_o;
    // a response transfers on a rising edge where rsp_valid_o && rsp_ready_i. A source
    // keeps its payload stable while valid is high and not yet accepted.
    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output apb_paddr_o, apb_pprot_o, apb_psel_o, apb_penable_o, apb_pwrite_o,
        output apb_pwdata_o, apb_pstrb_o,
        input  apb_pready_i, apb_prdata_i, apb_pslverr_i
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  apb_paddr_o, apb_pprot_o, apb_psel_o, apb_penable_o, apb_pwrite_o,
        input  apb_pwdata_o, apb_pstrb_o,
        output apb_pready_i, apb_prdata_i, apb_pslverr_i
    );

endinterface

// File: rtl/apb4_mst_wdt.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the cycle that reaches the limit.
// A limit of 0 disables the watchdog entirely.
module apb4_mst_wdt
    import apb4_mst_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at the limit so a long stall can never wrap back to a small count.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != CNT_SAT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expires in the stalled cycle that brings the count up to the limit.
    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/apb4_mst_bridge.sv
// Single-outstanding command/response to APB4 master bridge with SETUP/ACCESS sequencing,
// slave error reporting and an ACCESS-phase timeout.
module apb4_mst_bridge
    import apb4_mst_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    apb4_mst_bridge_if.master  bus,
    output state_e             dbg_state_o
);
    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic                  ready_q;
    logic                  accept;
    logic                  wdt_en;
    logic                  wdt_expired;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [2:0]            prot_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    err_e                  err_q;

    assign accept = bus.req_valid_i && ready_q;
    assign wdt_en = (state_q == ST_ACCESS) && !bus.apb_pready_i;

    apb4_mst_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (accept),
        .enable_i  (wdt_en),
        .expired_o (wdt_expired)
    );

    // ready is registered so it stays low while reset is held and rises one cycle after release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (bus.apb_pready_i || wdt_expired) state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Read commands latch zero write data and strobes so the bus never shows stale bytes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr_i;
                write_q <= bus.req_write_i;
                prot_q  <= bus.req_prot_i;
                wdata_q <= bus.req_write_i ? bus.req_wdata_i : '0;
                strb_q  <= bus.req_write_i ? bus.req_strb_i  : '0;
            end
            if (state_q == ST_ACCESS) begin
                if (bus.apb_pready_i) begin
                    rdata_q <= write_q ? '0 : bus.apb_prdata_i;
                    err_q   <= bus.apb_pslverr_i ? ERR_SLVERR : ERR_OK;
                end else if (wdt_expired) begin
                    rdata_q <= '0;
                    err_q   <= ERR_TIMEOUT;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready_o   = ready_q;
        bus.apb_psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        bus.apb_penable_o = (state_q == ST_ACCESS);
        bus.rsp_valid_o   = (state_q == ST_RESP);
        bus.apb_paddr_o   = addr_q;
        bus.apb_pprot_o   = prot_q;
        bus.apb_pwrite_o  = write_q;
        bus.apb_pwdata_o  = wdata_q;
        bus.apb_pstrb_o   = strb_q;
        bus.rsp_rdata_o   = rdata_q;
        bus.rsp_err_o     = err_q;
        dbg_state_o       = state_q;
    end

endmodule

// File: tb/tb_apb4_mst_bridge.sv
// Directed bench for apb4_mst_bridge: a scripted APB slave, a response scoreboard
// and checks on phase timing, bus stability, errors, timeout and reset.
module tb_apb4_mst_bridge;
    import apb4_mst_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg_state;

    int tests = 0;
    int fails = 0;

    // Scoreboard entries are {rsp_err, rsp_rdata}.
    logic [DW+1:0] exp_q[$];

    apb4_mst_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    apb4_mst_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus_if.master),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "tb watchdog expired");
    end

    // ---------------- checks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus_if.req_valid_i   = 1'b0;
        bus_if.req_write_i   = 1'b0;
        bus_if.req_addr_i    = '0;
        bus_if.req_wdata_i   = '0;
        bus_if.req_strb_i    = '0;
        bus_if.req_prot_i    = '0;
        bus_if.rsp_ready_i   = 1'b0;
        bus_if.apb_pready_i  = 1'b0;
        bus_if.apb_prdata_i  = '0;
        bus_if.apb_pslverr_i = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                        input logic [2:0] prot, input int waits, input logic slverr,
                        input logic [DW-1:0] prdata, input logic stuck, input int hold);
        logic [1:0]    e_err;
        logic [DW-1:0] e_rdata;
        logic [DW+1:0] got;
        logic [DW+1:0] exp;
        int            exp_acc;
        int            n_acc;
        logic          stable_ok;
        logic          hold_ok;
        logic [DW-1:0] e_pwdata;
        logic [SW-1:0] e_pstrb;

        e_pwdata = wr ? wdata : '0;
        e_pstrb  = wr ? strb  : '0;
        if (stuck) begin
            e_err = 2'd2; e_rdata = '0; exp_acc = TMO;
        end else begin
            e_err = slverr ? 2'd1 : 2'd0; e_rdata = wr ? '0 : prdata; exp_acc = waits + 1;
        end
        exp_q.push_back({e_err, e_rdata});

        @(negedge clk);
        check({tag, ":req_ready_idle"}, bus_if.req_ready_o, 1);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = wr;
        bus_if.req_addr_i  = addr;
        bus_if.req_wdata_i = wdata;
        bus_if.req_strb_i  = strb;
        bus_if.req_prot_i  = prot;

        // SETUP cycle: request fields are scrambled to prove they were latched.
        @(negedge clk);
        bus_if.req_valid_i = 1'b0;
        bus_if.req_addr_i  = $urandom();
        bus_if.req_wdata_i = $urandom();
        bus_if.req_strb_i  = SW'($urandom_range(0, (1 << SW) - 1));
        bus_if.req_write_i = ~wr;
        check({tag, ":setup_sel_en"}, {bus_if.apb_psel_o, bus_if.apb_penable_o}, 2'b10);
        check({tag, ":setup_ctrl"}, {bus_if.apb_paddr_o, bus_if.apb_pwrite_o, bus_if.apb_pprot_o},
              {addr, wr, prot});
        check({tag, ":setup_data"}, {bus_if.apb_pwdata_o, bus_if.apb_pstrb_o}, {e_pwdata, e_pstrb});
        check({tag, ":setup_req_ready"}, bus_if.req_ready_o, 0);

        @(negedge clk);
        n_acc = 0;
        stable_ok = 1'b1;
        while (bus_if.apb_psel_o && bus_if.apb_penable_o && n_acc < 32) begin
            n_acc++;
            if (bus_if.apb_paddr_o !== addr || bus_if.apb_pwrite_o !== wr ||
                bus_if.apb_pprot_o !== prot || bus_if.apb_pwdata_o !== e_pwdata ||
                bus_if.apb_pstrb_o !== e_pstrb || bus_if.rsp_valid_o !== 1'b0)
                stable_ok = 1'b0;
            bus_if.apb_pready_i  = !stuck && (n_acc == waits + 1);
            bus_if.apb_pslverr_i = bus_if.apb_pready_i ? slverr : 1'($urandom_range(0, 1));
            bus_if.apb_prdata_i  = bus_if.apb_pready_i ? prdata : $urandom();
            @(negedge clk);
        end
        // Junk on the slave inputs outside ACCESS must not disturb the response.
        bus_if.apb_pready_i  = 1'b1;
        bus_if.apb_pslverr_i = 1'b1;
        bus_if.apb_prdata_i  = $urandom();
        check({tag, ":access_cycles"}, n_acc, exp_acc);
        check({tag, ":access_stable"}, stable_ok, 1);
        check({tag, ":resp_phase"}, {bus_if.apb_psel_o, bus_if.apb_penable_o, bus_if.rsp_valid_o},
              3'b001);

        got = {bus_if.rsp_err_o, bus_if.rsp_rdata_o};
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (bus_if.rsp_valid_o !== 1'b1 || {bus_if.rsp_err_o, bus_if.rsp_rdata_o} !== got ||
                bus_if.req_ready_o !== 1'b0 || bus_if.apb_psel_o !== 1'b0)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        if (bus_if.rsp_valid_o !== 1'b1 || {bus_if.rsp_err_o, bus_if.rsp_rdata_o} !== got)
            hold_ok = 1'b0;
        check({tag, ":resp_hold"}, hold_ok, 1);

        bus_if.rsp_ready_i = 1'b1;
        exp = exp_q.pop_front();
        check({tag, ":resp_data"}, {bus_if.rsp_err_o, bus_if.rsp_rdata_o}, exp);

        @(negedge clk);
        bus_if.rsp_ready_i   = 1'b0;
        bus_if.apb_pready_i  = 1'b0;
        bus_if.apb_pslverr_i = 1'b0;
        check({tag, ":back_to_idle"}, {bus_if.rsp_valid_o, bus_if.req_ready_o}, 2'b01);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic quiet;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.apb_psel_o, bus_if.apb_penable_o,
               bus_if.apb_pwrite_o, bus_if.rsp_err_o}, 7'b0);
        check("reset_buses", {bus_if.apb_paddr_o, bus_if.apb_pwdata_o, bus_if.apb_pstrb_o,
                              bus_if.rsp_rdata_o}, '0);
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", bus_if.req_ready_o, 1);

        xfer("wr_fast",   1'b1, 32'h10, 32'h0000_1234, 4'hF, 3'd0, 0, 1'b0, 32'hAAAA_5555, 1'b0, 0);
        xfer("rd_wait3",  1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'd2, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer("wr_slverr", 1'b1, 32'h20, 32'h0BAD_F00D, 4'h3, 3'd1, 1, 1'b1, 32'h1234_5678, 1'b0, 1);
        xfer("rd_timeout",1'b0, 32'h30, 32'h0,         4'h0, 3'd0, 0, 1'b0, 32'hCAFE_CAFE, 1'b1, 0);
        xfer("wr_hold5",  1'b1, 32'h44, 32'h5A5A_A5A5, 4'hC, 3'd7, 2, 1'b0, 32'h0,         1'b0, 5);
        xfer("rd_slverr", 1'b0, 32'h48, 32'h0,         4'h0, 3'd3, 1, 1'b1, 32'h7777_0001, 1'b0, 2);

        for (int k = 0; k < 4; k++) begin
            xfer("rand", 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                 SW'($urandom_range(0, (1 << SW) - 1)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)), $urandom(),
                 1'b0, $urandom_range(0, 3));
        end

        // Reset while a read is stalled in ACCESS: no response may ever appear.
        @(negedge clk);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = 1'b0;
        bus_if.req_addr_i  = 32'h40;
        bus_if.req_prot_i  = 3'd5;
        @(negedge clk);
        bus_if.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_in_access", {bus_if.apb_psel_o, bus_if.apb_penable_o}, 2'b11);
        rst = 1'b1;
        bus_if.rsp_ready_i = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs",
              {bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.apb_psel_o, bus_if.apb_penable_o,
               bus_if.rsp_err_o, bus_if.apb_pprot_o}, 9'b0);
        check("rst_mid_buses", {bus_if.apb_paddr_o, bus_if.rsp_rdata_o}, '0);
        rst = 1'b0;
        bus_if.rsp_ready_i = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid_o !== 1'b0 || bus_if.apb_psel_o !== 1'b0) quiet = 1'b0;
        end
        check("rst_mid_no_response", quiet, 1);
        check("rst_mid_ready", bus_if.req_ready_o, 1);

        xfer("after_rst", 1'b0, 32'h50, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h0123_4567, 1'b0, 0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
